mod_delay: RTL

MOD_DELAY -- requirements
Module: mod_delay

---
 rtl/daf_pkg.sv | 21 ++
 rtl/delay_ram.sv | 31 +++
 rtl/mod_delay.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/daf_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// daf_pkg : shared FSM state and mode encodings for the modulated delay block
// Rev 1.0
// ----------------------------------------------------------------------------
package daf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_MIX   = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_ECHO   = 2'b01;
    localparam logic [1:0] MODE_FLANGE = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/delay_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// delay_ram : single-channel delay storage, synchronous write, registered read
// Rev 1.0
// ----------------------------------------------------------------------------
module delay_ram #(
    parameter int W     = 16,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [W-1:0]             rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/mod_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mod_delay : multichannel echo / flange delay effect, one sample per strobe
// Rev 1.0
// ----------------------------------------------------------------------------
module mod_delay
    import daf_pkg::*;
#(
    parameter int W     = 16,
    parameter int NCH   = 2,
    parameter int DEPTH = 256
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             shift_en,
    input  logic             effect_en,
    input  logic [1:0]       mode,
    input  logic [3:0]       pot_depth,
    input  logic [NCH*W-1:0] input_data,
    output logic [NCH*W-1:0] output_data,
    output logic             out_valid,
    output logic             overrun
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [NCH*W-1:0]  sample;
    logic [NCH*W-1:0]  mix;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_addr;
    logic [AW:0]       fill;
    logic [AW:0]       phase;
    logic [AW:0]       dly;
    logic [AW:0]       echo_d;
    logic [AW:0]       flange_d;
    logic [AW-1:0]     tri_wave;
    logic [AW+3:0]     tri_prod;
    logic              use_bypass;
    logic              tap_ok;
    logic              bypass_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (shift_en) state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_MIX;
            ST_MIX:   state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Delay selection; only consumed during CALC, so mode/pot changes land on the next sample.
    always_comb begin
        use_bypass = !effect_en || (mode == MODE_BYPASS) || (mode == MODE_RSVD);

        echo_d = {{(AW-3){1'b0}}, pot_depth} << (AW - 4);
        if (echo_d == '0) begin
            echo_d = (AW+1)'(1);
        end else if (echo_d > (AW+1)'(DEPTH-1)) begin
            echo_d = (AW+1)'(DEPTH-1);
        end

        tri_wave = phase[AW] ? ~phase[AW-1:0] : phase[AW-1:0];
        tri_prod = {4'b0000, tri_wave} * {{AW{1'b0}}, pot_depth};
        flange_d = {1'b0, tri_prod[AW+3:4]} + (AW+1)'(1);

        dly = (mode == MODE_FLANGE) ? flange_d : echo_d;
    end

    assign rd_addr = wr_ptr - dly[AW-1:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sample      <= '0;
            output_data <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            wr_ptr      <= '0;
            fill        <= '0;
            phase       <= '0;
            tap_ok      <= 1'b0;
            bypass_q    <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (shift_en && (state != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (shift_en) sample <= input_data;
                end
                ST_CALC: begin
                    // Taps older than the history actually written read as silence.
                    tap_ok   <= (dly <= fill);
                    bypass_q <= use_bypass;
                end
                ST_MIX: begin
                    output_data <= mix;
                    out_valid   <= 1'b1;
                end
                ST_WRITE: begin
                    wr_ptr <= wr_ptr + AW'(1);
                    phase  <= phase + (AW+1)'(1);
                    if (fill != (AW+1)'(DEPTH)) begin
                        fill <= fill + (AW+1)'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [W-1:0]        x;
        logic [W-1:0]        tap;
        logic signed [W:0]   sum;

        assign x = sample[k*W +: W];

        delay_ram #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_ram (
            .clk     (clk),
            .wr_en   (state == ST_WRITE),
            .wr_addr (wr_ptr),
            .wr_data (x),
            .rd_en   (state == ST_CALC),
            .rd_addr (rd_addr),
            .rd_data (tap)
        );

        // One guard bit makes the halved sum always fit back into W bits.
        assign sum = {x[W-1], x} + (tap_ok ? {tap[W-1], tap} : {(W+1){1'b0}});
        assign mix[k*W +: W] = bypass_q ? x : W'(sum >>> 1);
    end

endmodule
`default_nettype wire
